// File: rtl/shift_pkg.sv
// Shared definitions for the serial link: receiver FSM states and the default frame width.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SHIFT_WIDTH = 8;

endpackage

// File: rtl/deser_shiftreg.sv
// Right-shifting capture register: serial bits enter at the MSB so the first bit lands in bit 0.
module deser_shiftreg
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] base;

    // clear together with shift_en loads serial_in into an otherwise empty register
    always_comb begin
        base = clear ? '0 : q;
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            q <= {serial_in, base[WIDTH-1:1]};
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// LSB-first serial-to-parallel receiver: framed by start, one bit per bit_valid, word out with a valid pulse.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             abort,
    output state_t           dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr_q;
    logic             sr_clear;
    logic             sr_shift;
    logic             final_bit;

    // Handshake: bit_valid qualifies serial_in on the edge it is high (no back-pressure);
    // data_valid is a one-cycle pulse marking the edge data_out was refreshed.
    always_comb begin
        sr_clear  = reset | start;
        sr_shift  = !reset && bit_valid && ((state == IDLE) ? start : !start);
        final_bit = (state == SHIFT) && bit_valid && !start && (count == LAST);
    end

    deser_shiftreg #(.WIDTH(WIDTH)) u_shiftreg (
        .clk       (clk),
        .clear     (sr_clear),
        .shift_en  (sr_shift),
        .serial_in (serial_in),
        .q         (sr_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            abort      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            abort      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        count <= bit_valid ? CW'(1) : '0;
                    end
                end
                SHIFT: begin
                    // a restart wins over a bit arriving on the same edge, even the last one
                    if (start) begin
                        abort <= 1'b1;
                        count <= '0;
                    end else if (final_bit) begin
                        data_out   <= {serial_in, sr_q[WIDTH-1:1]};
                        data_valid <= 1'b1;
                        state      <= IDLE;
                        count      <= '0;
                    end else if (bit_valid) begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign busy      = (state == SHIFT);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: hand-computed frames, restarts, reset and idle noise.
module tb_shift_deserializer;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       serial_in;
    logic       bit_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       abort;
    state_t     dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int abort_cnt = 0;
    int dv_cnt   = 0;
    logic [7:0] last_word = 8'h00;
    logic [7:0] exp_q[$];

    shift_deserializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .abort      (abort),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every data_valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (!reset) begin
            check("excl_dv_abort", 32'(data_valid & abort), 32'h0);
            if (abort) abort_cnt++;
            if (data_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_dv", 32'(data_valid), 32'h0);
                end else begin
                    check("sb_word", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver tasks
    task automatic cycle(input logic s, input logic bv, input logic si);
        start     = s;
        bit_valid = bv;
        serial_in = si;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input int gap, input bit with_start);
        for (int i = 0; i < n; i++) begin
            cycle(with_start && (i == 0), 1'b1, w[i]);
            if (i < 7) begin
                check("busy_bit", 32'(busy), 32'h1);
                check("dv_bit", 32'(data_valid), 32'h0);
                check("hold_bit", 32'(data_out), 32'(last_word));
                check("abort_bit", 32'(abort), 32'h0);
            end
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    cycle(1'b0, 1'b0, 1'b0);
                    check("busy_gap", 32'(busy), 32'h1);
                    check("dv_gap", 32'(data_valid), 32'h0);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input int gap, input bit with_start);
        exp_q.push_back(w);
        send_bits(w, 8, gap, with_start);
        check("frame_dv", 32'(data_valid), 32'h1);
        check("frame_word", 32'(data_out), 32'(w));
        check("frame_busy", 32'(busy), 32'h0);
        last_word = w;
    endtask

    initial begin
        int c1;
        int dv_before;
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_abort", 32'(abort), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;

        // back-to-back bits, start with bit 0
        dv_before = dv_cnt;
        send_frame(8'hA5, 0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("a5_dv_drop", 32'(data_valid), 32'h0);
        check("a5_hold", 32'(data_out), 32'hA5);
        check("a5_pulses", 32'(dv_cnt - dv_before), 32'h1);

        // gaps of three idle cycles between bits
        dv_before = dv_cnt;
        send_frame(8'hA5, 3, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("gap_pulses", 32'(dv_cnt - dv_before), 32'h1);

        // restart after five bits, then a full frame from count 0
        send_bits(8'h5A, 5, 0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("restart_abort", 32'(abort), 32'h1);
        check("restart_dv", 32'(data_valid), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        check("restart_hold", 32'(data_out), 32'hA5);
        send_frame(8'h3C, 0, 1'b0);

        // restart on the final-bit edge drops that bit
        send_bits(8'h77, 7, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("lastbit_abort", 32'(abort), 32'h1);
        check("lastbit_dv", 32'(data_valid), 32'h0);
        check("lastbit_hold", 32'(data_out), 32'h3C);
        check("lastbit_state", 32'(dbg_state), 32'(SHIFT));
        send_frame(8'hC3, 0, 1'b0);
        check("abort_total", 32'(abort_cnt), 32'h2);

        // reset mid-frame: everything clears, no abort
        send_bits(8'h0F, 4, 0, 1'b1);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_abort", 32'(abort), 32'h0);
        check("midrst_dv", 32'(data_valid), 32'h0);
        reset = 1'b0;
        last_word = 8'h00;
        send_frame(8'hFF, 0, 1'b1);
        check("abort_after_rst", 32'(abort_cnt), 32'h2);

        // back-to-back frames, second start in the data_valid cycle
        send_frame(8'h01, 0, 1'b1);
        c1 = cyc;
        send_frame(8'h80, 0, 1'b1);
        check("b2b_spacing", 32'(cyc - c1), 32'd8);

        // bit_valid noise while idle
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'(i % 2), 1'b1);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_dv", 32'(data_valid), 32'h0);
            check("idle_hold", 32'(data_out), 32'h80);
        end

        cycle(1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
